// File: rtl/lru_pkg.sv
// Shared types and rank arithmetic for the counter-based LRU controller.
//   lru_op_e  : update opcode carried on op_type (TOUCH / INVAL)
//   rank_next : new rank of one way given the target way's current rank
package lru_pkg;

  typedef enum logic {
    LRU_TOUCH = 1'b0,
    LRU_INVAL = 1'b1
  } lru_op_e;

  // Ranks are passed zero-extended to 32 bits so one function serves any way
  // count. The target's old rank splits the set into two groups. Only the
  // group on one side of it moves by one step, so no rank can wrap.
  function automatic logic [31:0] rank_next(input logic [31:0] cur,
                                            input logic [31:0] tgt_cur,
                                            input logic        is_tgt,
                                            input lru_op_e     op,
                                            input logic [31:0] top);
    logic [31:0] res;
    res = cur;
    if (op == LRU_TOUCH) begin
      if (is_tgt)              res = top;
      else if (cur > tgt_cur)  res = cur - 32'd1;
    end else begin
      if (is_tgt)              res = 32'd0;
      else if (cur < tgt_cur)  res = cur + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lru_set_update.sv
// Combinational next-state for one set of the LRU controller.
//   cnt_cur / vld_cur : current rank counters and valid bits of the set
//   op, way           : requested update and target way
//   cnt_nxt / vld_nxt : state of the set after the update
module lru_set_update
  import lru_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] cnt_cur,
  input  logic [NUM_WAYS-1:0]            vld_cur,
  input  lru_op_e                        op,
  input  logic [WAY_W-1:0]               way,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] cnt_nxt,
  output logic [NUM_WAYS-1:0]            vld_nxt
);

  logic [WAY_W-1:0] tgt_cnt;

  always_comb begin
    tgt_cnt = cnt_cur[way];
    cnt_nxt = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      cnt_nxt[w] = WAY_W'(rank_next(32'(cnt_cur[w]), 32'(tgt_cnt),
                                    (WAY_W'(w) == way), op,
                                    32'(NUM_WAYS - 1)));
    end
    vld_nxt      = vld_cur;
    vld_nxt[way] = (op == LRU_TOUCH);
  end

endmodule

// File: rtl/set_counter_lru.sv
// Multi-set counter-based LRU replacement controller.
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : one-cycle pulse returning every set to reset state
//   op_valid/op_type/op_set/op_way : TOUCH or INVAL of one way of one set
//   lock_mask         : ways excluded from victim choice in every set
//   vic_req/vic_set   : victim query, answered one cycle later
//   vic_valid/vic_way/vic_none : registered victim result (none = all locked)
module set_counter_lru
  import lru_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 8,
  parameter int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                op_valid,
  input  lru_op_e             op_type,
  input  logic [SET_W-1:0]    op_set,
  input  logic [WAY_W-1:0]    op_way,
  input  logic [NUM_WAYS-1:0] lock_mask,
  input  logic                vic_req,
  input  logic [SET_W-1:0]    vic_set,
  output logic                vic_valid,
  output logic [WAY_W-1:0]    vic_way,
  output logic                vic_none
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] cnt_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            vld_q;

  logic [NUM_WAYS-1:0][WAY_W-1:0] upd_cnt;
  logic [NUM_WAYS-1:0]            upd_vld;
  logic [WAY_W:0]                 vic_sel_p0;

  logic                vic_vld_p1;
  logic [WAY_W-1:0]    vic_way_p1;
  logic                vic_none_p1;

  // Invalid unlocked ways are preferred (lowest index), then the unlocked way
  // with the smallest rank. Ranks are unique, so the strict compare has no ties.
  function automatic logic [WAY_W:0] pick_victim(
      input logic [NUM_WAYS-1:0][WAY_W-1:0] cnt,
      input logic [NUM_WAYS-1:0]            vld,
      input logic [NUM_WAYS-1:0]            lock);
    logic             found_inv;
    logic             any_unlocked;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] lru_cnt;
    found_inv    = 1'b0;
    any_unlocked = 1'b0;
    inv_way      = '0;
    lru_way      = '0;
    lru_cnt      = '1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!lock[w] && !vld[w]) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!lock[w] && (!any_unlocked || cnt[w] < lru_cnt)) begin
        any_unlocked = 1'b1;
        lru_cnt      = cnt[w];
        lru_way      = WAY_W'(w);
      end
    end
    if (!any_unlocked) return {1'b1, {WAY_W{1'b0}}};
    else if (found_inv) return {1'b0, inv_way};
    else return {1'b0, lru_way};
  endfunction

  // Only the addressed set goes through the update logic. The result is
  // written back to that set alone.
  lru_set_update #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_upd (
    .cnt_cur (cnt_q[op_set]),
    .vld_cur (vld_q[op_set]),
    .op      (op_type),
    .way     (op_way),
    .cnt_nxt (upd_cnt),
    .vld_nxt (upd_vld)
  );

  // p0: victim chosen from pre-edge state, so a same-cycle op is not seen
  always_comb begin
    vic_sel_p0 = pick_victim(cnt_q[vic_set], vld_q[vic_set], lock_mask);
  end

  // p0 -> p1: state update and registered victim result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          cnt_q[s][w] <= WAY_W'(w);
        end
      end
      vld_q       <= '0;
      vic_vld_p1  <= 1'b0;
      vic_way_p1  <= '0;
      vic_none_p1 <= 1'b0;
    end else begin
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            cnt_q[s][w] <= WAY_W'(w);
          end
        end
        vld_q <= '0;
      end else if (op_valid) begin
        cnt_q[op_set] <= upd_cnt;
        vld_q[op_set] <= upd_vld;
      end
      // A flush in the same cycle still answers from the pre-flush state.
      vic_vld_p1 <= vic_req;
      if (vic_req) begin
        vic_way_p1  <= vic_sel_p0[WAY_W-1:0];
        vic_none_p1 <= vic_sel_p0[WAY_W];
      end
    end
  end

  assign vic_valid = vic_vld_p1;
  assign vic_way   = vic_way_p1;
  assign vic_none  = vic_none_p1;

endmodule
